// File: rtl/iob_eth_mem_arbiter.sv
// Round-robin arbiter sharing one IOb-native memory slave port between N_MASTERS
// IOb-native masters; one transaction outstanding, with an optional bus timeout.
module iob_eth_mem_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_MASTERS-1:0]              m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]       m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]       m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0]   m_wstrb,
  output logic [DATA_W-1:0]                 m_rdata,
  output logic [N_MASTERS-1:0]              m_ready,
  output logic [N_MASTERS-1:0]              m_err,
  output logic                              s_valid,
  output logic [ADDR_W-1:0]                 s_addr,
  output logic [DATA_W-1:0]                 s_wdata,
  output logic [DATA_W/8-1:0]               s_wstrb,
  input  logic [DATA_W-1:0]                 s_rdata,
  input  logic                              s_ready,
  output logic [$clog2(N_MASTERS)-1:0]      grant
);

  localparam int          GW       = $clog2(N_MASTERS);
  localparam int          SW       = DATA_W / 8;
  localparam int unsigned NM       = N_MASTERS;
  localparam int          CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] pick;
  logic [GW-1:0] idx_g;
  int unsigned   idx;
  logic          timeout_hit;

  // Scan from the farthest candidate to the nearest so the first requester after
  // grant_q is the last one written and therefore wins.
  always_comb begin
    pick  = grant_q;
    idx   = 0;
    idx_g = '0;
    for (int unsigned k = NM; k >= 1; k--) begin
      idx   = (32'(grant_q) + k) % NM;
      idx_g = GW'(idx);
      if (m_valid[idx_g]) pick = idx_g;
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|m_valid) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (s_ready || timeout_hit) state_d = IDLE;
        else if (TIMEOUT != 0)      cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_valid = (state_q == BUSY);
    s_addr  = m_addr[grant_q*ADDR_W +: ADDR_W];
    s_wdata = m_wdata[grant_q*DATA_W +: DATA_W];
    s_wstrb = m_wstrb[grant_q*SW +: SW];
    m_ready = '0;
    m_err   = '0;
    m_rdata = '0;
    // A reset landing mid-transaction aborts it silently.
    if (state_q == BUSY && !rst) begin
      if (s_ready) begin
        m_ready[grant_q] = 1'b1;
        m_rdata          = s_rdata;
      end else if (timeout_hit) begin
        m_ready[grant_q] = 1'b1;
        m_err[grant_q]   = 1'b1;
      end
    end
  end

  assign grant = grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= GW'(N_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
